// File: rtl/async_rd_ptr_wsync_if.sv
// rtl/async_rd_ptr_wsync_if.sv - read-pointer sync bundle between FIFO pointer logic and the write-side monitor
interface async_rd_ptr_wsync_if #(
  parameter int AW = 2
);
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic        wm_clr;
  logic        err_clr;
  logic [AW:0] rd_ptr_wsync;
  logic [AW:0] fifo_level;
  logic        almost_full;
  logic [AW:0] watermark;
  logic        gray_err;
  logic        ptr_overrun;

  modport master (
    output rd_ptr, wr_ptr, wm_clr, err_clr,
    input  rd_ptr_wsync, fifo_level, almost_full, watermark, gray_err, ptr_overrun
  );

  modport slave (
    input  rd_ptr, wr_ptr, wm_clr, err_clr,
    output rd_ptr_wsync, fifo_level, almost_full, watermark, gray_err, ptr_overrun
  );
endinterface

// File: rtl/async_rd_ptr_wsync.sv
// rtl/async_rd_ptr_wsync.sv - write-domain read-pointer synchroniser with occupancy, almost-full and error monitors
module async_rd_ptr_wsync #(
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int AFULL_HYST   = 1
) (
  input logic                 wr_clk,
  input logic                 rst,
  async_rd_ptr_wsync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] SET_V   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] CLR_V   = PW'(AFULL_THRESH - AFULL_HYST);

  typedef enum logic {NORMAL, AFULL} af_state_e;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] fifo_level_q, fifo_level_d;
  logic [PW-1:0] watermark_q, watermark_d;
  logic          gray_err_q, gray_err_d;
  logic          ptr_overrun_q, ptr_overrun_d;
  logic          valid_q, valid_d;
  af_state_e     state_q, state_d;

  logic [PW-1:0] rd_ptr_wsync;
  logic [PW-1:0] level_calc;
  logic          gray_bad;
  logic          overrun_now;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign rd_ptr_wsync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // Plain shift register: stage 0 samples the asynchronous pointer directly.
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.rd_ptr};
    prev_d = rd_ptr_wsync;
    valid_d = 1'b1;

    level_calc  = g2b(bus.wr_ptr) - g2b(rd_ptr_wsync);
    overrun_now = (level_calc > DEPTH_V);
    // valid_q masks the comparison against the reset value of prev on the first cycle.
    gray_bad    = valid_q && ($countones(prev_q ^ rd_ptr_wsync) > 1);

    fifo_level_d  = level_calc;
    gray_err_d    = gray_bad || (gray_err_q && !bus.err_clr);
    ptr_overrun_d = overrun_now || (ptr_overrun_q && !bus.err_clr);

    if (bus.wm_clr) begin
      watermark_d = fifo_level_q;
    end else if (fifo_level_q > watermark_q) begin
      watermark_d = fifo_level_q;
    end else begin
      watermark_d = watermark_q;
    end

    state_d = state_q;
    case (state_q)
      NORMAL: if (fifo_level_q >= SET_V) state_d = AFULL;
      AFULL:  if (fifo_level_q < CLR_V) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      sync_q        <= '0;
      prev_q        <= '0;
      fifo_level_q  <= '0;
      watermark_q   <= '0;
      gray_err_q    <= 1'b0;
      ptr_overrun_q <= 1'b0;
      valid_q       <= 1'b0;
      state_q       <= NORMAL;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      fifo_level_q  <= fifo_level_d;
      watermark_q   <= watermark_d;
      gray_err_q    <= gray_err_d;
      ptr_overrun_q <= ptr_overrun_d;
      valid_q       <= valid_d;
      state_q       <= state_d;
    end
  end

  assign bus.rd_ptr_wsync = rd_ptr_wsync;
  assign bus.fifo_level   = fifo_level_q;
  assign bus.almost_full  = (state_q == AFULL);
  assign bus.watermark    = watermark_q;
  assign bus.gray_err     = gray_err_q;
  assign bus.ptr_overrun  = ptr_overrun_q;
endmodule

// File: tb/tb_async_rd_ptr_wsync.sv
// tb/tb_async_rd_ptr_wsync.sv - directed and random checks of async_rd_ptr_wsync against a cycle reference model
module tb_async_rd_ptr_wsync;
  localparam int DEPTH  = 8;
  localparam int SS     = 2;
  localparam int THRESH = 6;
  localparam int HYST   = 2;
  localparam int AW     = 3;

  logic wr_clk = 1'b0;
  logic rst;
  always #5 wr_clk = ~wr_clk;

  async_rd_ptr_wsync_if #(.AW(AW)) bus ();

  async_rd_ptr_wsync #(
    .DEPTH(DEPTH), .SYNC_STAGES(SS), .AFULL_THRESH(THRESH), .AFULL_HYST(HYST)
  ) dut (
    .wr_clk(wr_clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the synchroniser is just a delay queue of sampled pointers.
  logic [3:0] m_sync[$];
  logic [3:0] m_prev;
  bit         m_valid;
  int         m_level;
  bit         m_af;
  int         m_wm;
  bit         m_gerr;
  bit         m_ovr;

  int rb, wb, k;
  logic [3:0] rd_v;

  function automatic logic [3:0] g(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic int gbin(input logic [3:0] gv);
    for (int b = 0; b < 16; b++) begin
      if (g(b) == gv) return b;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input logic [3:0] rd, input logic [3:0] wr,
                            input bit wc, input bit ec);
    logic [3:0] ws;
    int nl;
    if (r) begin
      m_sync.delete();
      repeat (SS) m_sync.push_back(4'd0);
      m_prev = 0; m_valid = 0; m_level = 0; m_af = 0; m_wm = 0; m_gerr = 0; m_ovr = 0;
    end else begin
      ws = m_sync[$];
      nl = (gbin(wr) - gbin(ws) + 16) % 16;
      m_gerr = (m_valid && ($countones(m_prev ^ ws) > 1)) || (m_gerr && !ec);
      m_ovr  = (nl > DEPTH) || (m_ovr && !ec);
      if (!m_af && m_level >= THRESH) m_af = 1;
      else if (m_af && m_level < THRESH - HYST) m_af = 0;
      m_wm = wc ? m_level : ((m_level > m_wm) ? m_level : m_wm);
      m_level = nl;
      m_prev  = ws;
      m_valid = 1;
      m_sync.push_front(rd);
      void'(m_sync.pop_back());
    end
  endtask

  task automatic check_all();
    chk("rd_ptr_wsync", bus.rd_ptr_wsync, int'(m_sync[$]));
    chk("fifo_level",   bus.fifo_level,   m_level);
    chk("almost_full",  bus.almost_full,  int'(m_af));
    chk("watermark",    bus.watermark,    m_wm);
    chk("gray_err",     bus.gray_err,     int'(m_gerr));
    chk("ptr_overrun",  bus.ptr_overrun,  int'(m_ovr));
  endtask

  task automatic step(input bit r, input logic [3:0] rd, input logic [3:0] wr,
                      input bit wc, input bit ec);
    rst = r;
    bus.rd_ptr = rd;
    bus.wr_ptr = wr;
    bus.wm_clr = wc;
    bus.err_clr = ec;
    model_edge(r, rd, wr, wc, ec);
    @(posedge wr_clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_ptr = '0; bus.wr_ptr = '0; bus.wm_clr = 1'b0; bus.err_clr = 1'b0;
    m_sync.delete();
    repeat (SS) m_sync.push_back(4'd0);

    step(1, 4'b0000, 4'b0000, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0);
    chk("reset_level", bus.fifo_level, 0);
    chk("reset_af", bus.almost_full, 0);
    chk("reset_wm", bus.watermark, 0);
    chk("reset_flags", {bus.gray_err, bus.ptr_overrun}, 0);

    // Fill to 6, then almost_full one edge later.
    repeat (3) step(0, 4'b0000, 4'b0101, 0, 0);
    chk("t1_level", bus.fifo_level, 6);
    step(0, 4'b0000, 4'b0101, 0, 0);
    chk("t1_af", bus.almost_full, 1);
    chk("t1_wm", bus.watermark, 6);

    // Hysteresis: 5 and 4 hold, 3 releases, 5 does not re-assert.
    repeat (4) step(0, g(1), g(6), 0, 0);
    chk("t3_af_l5", bus.almost_full, 1);
    repeat (4) step(0, g(2), g(6), 0, 0);
    chk("t3_af_l4", bus.almost_full, 1);
    repeat (4) step(0, g(3), g(6), 0, 0);
    chk("t3_af_l3", bus.almost_full, 0);
    repeat (4) step(0, g(3), g(8), 0, 0);
    chk("t3_lvl5", bus.fifo_level, 5);
    chk("t3_af_l5b", bus.almost_full, 0);

    // Wrap-around occupancy.
    step(1, 4'b0000, 4'b0000, 0, 0);
    repeat (4) step(0, 4'b1011, 4'b0001, 0, 0);
    chk("t2_level", bus.fifo_level, 4);
    chk("t2_ovr", bus.ptr_overrun, 0);
    step(1, 4'b0000, 4'b0000, 0, 0);
    repeat (3) step(0, g(9), 4'b0000, 0, 0);
    repeat (2) step(0, g(9), g(9), 0, 0);
    chk("t2_empty", bus.fifo_level, 0);
    chk("t2_ovr_b", bus.ptr_overrun, 0);

    // Gray error timing and sticky clear behaviour.
    step(1, 4'b0000, 4'b0000, 0, 0);
    step(0, 4'b0011, 4'b0110, 0, 0);
    step(0, 4'b0011, 4'b0110, 0, 0);
    chk("t4_gerr_e2", bus.gray_err, 0);
    step(0, 4'b0011, 4'b0110, 0, 0);
    chk("t4_gerr_e3", bus.gray_err, 1);
    step(0, 4'b0000, 4'b0110, 0, 0);
    step(0, 4'b0000, 4'b0110, 0, 0);
    step(0, 4'b0000, 4'b0110, 0, 1);
    chk("t4_clr_vs_new", bus.gray_err, 1);
    step(0, 4'b0000, 4'b0110, 0, 1);
    chk("t4_clr", bus.gray_err, 0);

    // Overrun reports raw level; watermark reload.
    step(0, 4'b0000, 4'b1111, 0, 0);
    chk("t5_level", bus.fifo_level, 10);
    chk("t5_ovr", bus.ptr_overrun, 1);
    step(0, 4'b0000, g(3), 0, 0);
    step(0, 4'b0000, g(3), 1, 0);
    chk("t5_wm_clr", bus.watermark, 3);

    // Mid-operation reset.
    repeat (3) step(0, 4'b0000, g(6), 0, 0);
    chk("t6_af_pre", bus.almost_full, 1);
    step(1, 4'b0000, g(6), 0, 0);
    chk("t6_rst_level", bus.fifo_level, 0);
    chk("t6_rst_af", bus.almost_full, 0);
    chk("t6_rst_flags", {bus.gray_err, bus.ptr_overrun, bus.watermark}, 0);
    repeat (3) step(0, 4'b0000, g(6), 0, 0);
    chk("t6_recover", bus.fifo_level, 6);

    // Random mix of legal pointer motion, gray glitches, clears and resets.
    rb = 0; wb = 6;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 45) wb = (wb + 1) % 16;
      if ($urandom_range(0, 99) < 40) rb = (rb + 1) % 16;
      rd_v = ($urandom_range(0, 99) < 4) ? 4'($urandom) : g(rb);
      step(($urandom_range(0, 99) < 2), rd_v, g(wb),
           ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 10));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
